full_adder: RTL and testbench

- Registered ripple-carry full adder. Computes {cout, sum} = a + b + cin over WIDTH bits.
- With WIDTH=1 it is the classic 1-bit full adder: sum = a^b^cin, cout = majority(a,b,cin).
- Used as the basic arithmetic leaf in the NTT datapath (butterfly add paths). Results are registered, with a one-cycle valid pipeline.

---
 rtl/full_adder_pkg.sv | 15 +
 rtl/full_adder_if.sv | 25 ++
 rtl/full_adder_cell.sv | 15 +
 rtl/full_adder.sv | 59 +++++
 tb/tb_full_adder.sv | 134 +++++++++++++
 5 files changed

// File: rtl/full_adder_pkg.sv
// Shared arithmetic definitions for the NTT datapath: default operand width
// and single-bit full-adder equations usable by RTL and reference models.
package ntt_arith_pkg;

    localparam int FA_WIDTH_DEFAULT = 1;

    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/full_adder_if.sv
// Operand/result bundle for the registered full adder; master drives operands
// and observes results, slave is the adder itself.
interface full_adder_if #(
    parameter int WIDTH = 1
) ();

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin,
        input  out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin,
        output out_valid, sum, cout
    );

endinterface

// File: rtl/full_adder_cell.sv
// Purely combinational 1-bit full-adder cell; one link of the ripple chain.
module full_adder_cell
    import ntt_arith_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = fa_sum(a_i, b_i, c_i);
    assign c_o = fa_carry(a_i, b_i, c_i);

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder: {cout, sum} = a + b + cin, one cycle
// latency, one operation per cycle; outputs hold when no new operands arrive.
module full_adder
    import ntt_arith_pkg::*;
#(
    parameter int WIDTH = FA_WIDTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    full_adder_if.slave   bus
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    logic [WIDTH-1:0] sum_q,  sum_d;
    logic             cout_q, cout_d;
    logic             vld_q,  vld_d;

    assign carry[0] = bus.cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder_cell u_cell (
            .a_i (bus.a[i]),
            .b_i (bus.b[i]),
            .c_i (carry[i]),
            .s_o (sum_comb[i]),
            .c_o (carry[i+1])
        );
    end

    always_comb begin
        vld_d  = bus.in_valid;
        sum_d  = sum_q;
        cout_d = cout_q;
        if (bus.in_valid) begin
            sum_d  = sum_comb;
            cout_d = carry[WIDTH];
        end
    end

    // Reset wins over a same-cycle operand, discarding it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            vld_q  <= vld_d;
        end
    end

    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_full_adder.sv
// Directed checks of the registered full adder at WIDTH=1 and WIDTH=8.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    full_adder_if #(.WIDTH(1)) bus1 ();
    full_adder_if #(.WIDTH(8)) bus8 ();

    full_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    full_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic v, input logic a, input logic b, input logic c);
        bus1.in_valid = v;
        bus1.a        = a;
        bus1.b        = b;
        bus1.cin      = c;
    endtask

    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
        bus8.in_valid = v;
        bus8.a        = a;
        bus8.b        = b;
        bus8.cin      = c;
    endtask

    task automatic check8(input string tag, input logic v, input logic [7:0] s, input logic co);
        check({tag, "_vld"},  64'(bus8.out_valid), 64'(v));
        check({tag, "_sum"},  64'(bus8.sum),       64'(s));
        check({tag, "_cout"}, 64'(bus8.cout),      64'(co));
    endtask

    initial begin
        // Truth table indexed by {a,b,cin}
        logic [7:0] tt_sum;
        logic [7:0] tt_cout;
        logic [2:0] v;
        tt_sum  = 8'b1001_0110;
        tt_cout = 8'b1110_1000;

        rst = 1'b1;
        drive1(1'b0, 1'b0, 1'b0, 1'b0);
        drive8(1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        check("rst1_vld",  64'(bus1.out_valid), 64'd0);
        check("rst1_sum",  64'(bus1.sum),       64'd0);
        check("rst1_cout", 64'(bus1.cout),      64'd0);
        check8("rst8", 1'b0, 8'h00, 1'b0);

        // Reset overrides a valid operand set
        drive1(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check("rstov_vld",  64'(bus1.out_valid), 64'd0);
        check("rstov_sum",  64'(bus1.sum),       64'd0);
        check("rstov_cout", 64'(bus1.cout),      64'd0);

        rst = 1'b0;
        drive1(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("idle_vld", 64'(bus1.out_valid), 64'd0);

        // Back-to-back exhaustive 1-bit truth table
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            drive1(1'b1, v[2], v[1], v[0]);
            tick();
            check($sformatf("tt%0d_vld", i),  64'(bus1.out_valid), 64'd1);
            check($sformatf("tt%0d_sum", i),  64'(bus1.sum),       64'(tt_sum[i]));
            check($sformatf("tt%0d_cout", i), 64'(bus1.cout),      64'(tt_cout[i]));
        end
        drive1(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("tthold_vld",  64'(bus1.out_valid), 64'd0);
        check("tthold_sum",  64'(bus1.sum),       64'd1);
        check("tthold_cout", 64'(bus1.cout),      64'd1);

        // 8-bit carry ripple and overflow
        drive8(1'b1, 8'hFF, 8'h00, 1'b1);
        tick();
        check8("ripple_ff", 1'b1, 8'h00, 1'b1);
        drive8(1'b1, 8'h7F, 8'h01, 1'b0);
        tick();
        check8("ripple_7f", 1'b1, 8'h80, 1'b0);
        drive8(1'b1, 8'hFF, 8'hFF, 1'b1);
        tick();
        check8("maxovf", 1'b1, 8'hFF, 1'b1);

        // Single op then idle: one-cycle valid pulse, result holds
        drive8(1'b1, 8'h03, 8'h04, 1'b0);
        tick();
        check8("gate_op", 1'b1, 8'h07, 1'b0);
        drive8(1'b0, 8'hAA, 8'h55, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check8($sformatf("gate_idle%0d", i), 1'b0, 8'h07, 1'b0);
        end

        // Reset in the issue cycle: result is never presented
        drive8(1'b1, 8'h10, 8'h20, 1'b0);
        tick();
        check8("mid_op", 1'b1, 8'h30, 1'b0);
        drive8(1'b1, 8'h41, 8'h22, 1'b1);
        rst = 1'b1;
        tick();
        check8("mid_rst", 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        drive8(1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        check8("mid_after", 1'b0, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
